// File: rtl/wait_state_mem.sv
// wait_state_mem: word-addressed 32-bit memory responder with programmable
// read/write wait states and a one-cycle registered ready pulse.
//
// Optional feature macro: MEM_CONFLICT_CHECK_EN
//   defined   : err pulses with ready on a read+write conflict or when a
//               request drops before it completes
//   undefined : err is tied low and no detection logic is built
module wait_state_mem #(
   parameter int ADDR_BITS = 10,
   parameter int READ_LAT  = 3,
   parameter int WRITE_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic        err
);

   localparam int         DEPTH  = 2 ** ADDR_BITS;
   localparam logic [3:0] RD_LAT = 4'(READ_LAT);
   localparam logic [3:0] WR_LAT = 4'(WRITE_LAT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t                r_state;
   logic [3:0]            r_cnt;
   logic [ADDR_BITS-1:0]  r_idx;
   logic [31:0]           r_data;
   logic                  r_op_write;
   logic [31:0]           r_read_data;
   logic                  r_ready;
   logic [31:0]           r_mem [DEPTH];

   logic                  w_req;
   logic                  w_take;
   logic [ADDR_BITS-1:0]  w_new_idx;
   logic [3:0]            w_new_lat;
   logic                  w_go_resp;
   logic                  w_acc_write;
   logic [ADDR_BITS-1:0]  w_acc_idx;
   logic [31:0]           w_acc_data;
   logic                  w_commit;
   logic                  w_unused_addr;

   // Request decode; write wins when both strobes are set.
   assign w_req     = read | write;
   assign w_take    = (r_state == S_IDLE) && w_req;
   assign w_new_idx = address[ADDR_BITS+1:2];
   assign w_new_lat = write ? WR_LAT : RD_LAT;

   // Byte-lane bits and bits above the word index only alias.
   assign w_unused_addr = ^{address[31:ADDR_BITS+2], address[1:0]};

   // The edge that enters RESP is where the array is accessed. With a
   // one-cycle latency that is the sampling edge itself, so the operands
   // come straight from the ports; otherwise from the latched copies.
   assign w_go_resp   = (w_take && (w_new_lat == 4'd1)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd1));
   assign w_acc_write = (r_state == S_IDLE) ? write      : r_op_write;
   assign w_acc_idx   = (r_state == S_IDLE) ? w_new_idx  : r_idx;
   assign w_acc_data  = (r_state == S_IDLE) ? write_data : r_data;

   // A reset on the completing edge aborts the access: nothing is committed.
   assign w_commit = w_go_resp && w_acc_write && !reset;

   // Array write port.
   // NOTE: the array has no reset on purpose; clearing 2**ADDR_BITS words
   // would turn block RAM into flops, and contents must survive reset.
   always_ff @(posedge clk) begin
      if (w_commit) begin
         r_mem[w_acc_idx] <= w_acc_data;
      end
   end

   // Access FSM: latch the request, count wait states, issue one ready pulse.
   // NOTE: every register here uses non-blocking assignment so r_mem is read
   // with its pre-edge value and all state updates appear simultaneously.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= 4'd0;
         r_idx       <= '0;
         r_data      <= 32'd0;
         r_op_write  <= 1'b0;
         r_read_data <= 32'd0;
         r_ready     <= 1'b0;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_idx      <= w_new_idx;
                  r_data     <= write_data;
                  r_op_write <= write;
                  r_cnt      <= w_new_lat - 4'd1;
                  r_state    <= (w_new_lat == 4'd1) ? S_RESP : S_WAIT;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state <= S_RESP;
               end
            end
            // The requester still holds the old request here, so inputs
            // are ignored and the FSM simply returns to IDLE.
            S_RESP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase

         if (w_go_resp) begin
            r_ready <= 1'b1;
            if (!w_acc_write) begin
               r_read_data <= r_mem[w_acc_idx];
            end
         end
      end
   end

   assign read_data = r_read_data;
   assign ready     = r_ready;

`ifdef MEM_CONFLICT_CHECK_EN
   logic r_err;
   logic r_both;
   logic r_rd_held;
   logic r_wr_held;
   logic r_viol;
   logic w_drop;

   // A strobe that was set at acceptance and is now low during WAIT.
   assign w_drop = (r_state == S_WAIT) &&
                   ((r_rd_held && !read) || (r_wr_held && !write));

   // Conflict / protocol-violation tracking; err rides with ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_err     <= 1'b0;
         r_both    <= 1'b0;
         r_rd_held <= 1'b0;
         r_wr_held <= 1'b0;
         r_viol    <= 1'b0;
      end else begin
         if (w_take) begin
            r_both    <= read & write;
            r_rd_held <= read;
            r_wr_held <= write;
            r_viol    <= 1'b0;
         end else if (w_drop) begin
            r_viol <= 1'b1;
         end
         r_err <= w_go_resp &&
                  (w_take ? (read & write) : (r_both | r_viol | w_drop));
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_wait_state_mem.sv
// Self-checking bench for wait_state_mem: expected completions are queued
// when a request is driven and compared when the ready pulse arrives.
module tb_wait_state_mem;

   localparam int ADDR_BITS = 10;
   localparam int READ_LAT  = 3;
   localparam int WRITE_LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        read;
   logic        write;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic        err;

   wait_state_mem #(
      .ADDR_BITS (ADDR_BITS),
      .READ_LAT  (READ_LAT),
      .WRITE_LAT (WRITE_LAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .read       (read),
      .write      (write),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .ready      (ready),
      .err        (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      string       tag;
      logic [31:0] exp_data;
      int          exp_lat;
      logic        exp_err;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model_mem [int];
   logic [31:0] model_rd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   function automatic int widx(input logic [31:0] a);
      return int'(a[ADDR_BITS+1:2]);
   endfunction

   // Drive a request and queue what its completion must look like.
   task automatic issue(input string tag, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      e.tag     = tag;
      e.exp_lat = wr ? WRITE_LAT : READ_LAT;
`ifdef MEM_CONFLICT_CHECK_EN
      e.exp_err = rd && wr;
`else
      e.exp_err = 1'b0;
`endif
      if (wr) model_mem[widx(a)] = d;
      else if (model_mem.exists(widx(a))) model_rd = model_mem[widx(a)];
      else model_rd = 'x;
      e.exp_data = model_rd;
      sb.push_back(e);
      read       = rd;
      write      = wr;
      address    = a;
      write_data = d;
   endtask

   // Wait (bounded) for ready, compare against the queued entry, release the
   // request, and confirm ready drops after one cycle.
   task automatic complete(output int rdy_cyc);
      exp_t e;
      int   n;
      bit   seen;
      e       = sb.pop_front();
      n       = 0;
      seen    = 1'b0;
      rdy_cyc = -1;
      while (!seen && n < 40) begin
         @(posedge clk); #1;
         n++;
         seen = ready;
      end
      check({e.tag, "_ready"}, 32'(seen), 32'd1);
      if (seen) begin
         rdy_cyc = cyc;
         check({e.tag, "_lat"}, 32'(n), 32'(e.exp_lat));
         check({e.tag, "_err"}, 32'(err), 32'(e.exp_err));
         if (!$isunknown(e.exp_data)) check({e.tag, "_rdata"}, read_data, e.exp_data);
      end
      read  = 1'b0;
      write = 1'b0;
      @(posedge clk); #1;
      check({e.tag, "_pulse"}, 32'(ready), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int rc;
      int prev_rc;

      // Reset held 3 cycles with a read pending.
      reset = 1'b1;
      model_rd = 32'd0;
      issue("rst_read", 1'b1, 1'b0, 32'h300, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("rst_ready", 32'(ready), 32'd0);
         check("rst_rdata", read_data, 32'd0);
         check("rst_err", 32'(err), 32'd0);
      end
      reset = 1'b0;
      complete(rc);

      // Write then read.
      issue("wr_c8", 1'b0, 1'b1, 32'hC8, 32'hDEADBEEF);
      complete(rc);
      issue("rd_c8", 1'b1, 1'b0, 32'hC8, 32'd0);
      complete(rc);
      check("rd_c8_const", read_data, 32'hDEADBEEF);

      // Back-to-back writes then reads; period must be LAT+1.
      prev_rc = -1;
      for (int i = 0; i < 21; i++) begin
         issue($sformatf("b2b_wr%0d", i), 1'b0, 1'b1, 32'hC8 + 32'(4 * i), 32'(i * 32'h11));
         complete(rc);
         if (prev_rc >= 0) check("b2b_wr_period", 32'(rc - prev_rc), 32'(WRITE_LAT + 1));
         prev_rc = rc;
      end
      prev_rc = -1;
      for (int i = 0; i < 21; i++) begin
         issue($sformatf("b2b_rd%0d", i), 1'b1, 1'b0, 32'hC8 + 32'(4 * i), 32'd0);
         complete(rc);
         check($sformatf("b2b_rd%0d_val", i), read_data, 32'(i * 32'h11));
         if (prev_rc >= 0) check("b2b_rd_period", 32'(rc - prev_rc), 32'(READ_LAT + 1));
         prev_rc = rc;
      end

      // Reset during WAIT of a write: no ready, no commit.
      issue("wr_old", 1'b0, 1'b1, 32'h10, 32'hAAAAAAAA);
      complete(rc);
      read = 1'b0; write = 1'b1; address = 32'h10; write_data = 32'h12345678;
      @(posedge clk); #1;
      check("abort_wait_ready", 32'(ready), 32'd0);
      reset = 1'b1; write = 1'b0;
      @(posedge clk); #1;
      check("abort_ready", 32'(ready), 32'd0);
      check("abort_rdata", read_data, 32'd0);
      reset = 1'b0;
      model_rd = 32'd0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("abort_idle_ready", 32'(ready), 32'd0);
      end
      issue("rd_after_abort", 1'b1, 1'b0, 32'h10, 32'd0);
      complete(rc);
      check("abort_keep_old", read_data, 32'hAAAAAAAA);

      // Address aliasing: upper and byte-lane bits ignored.
      issue("wr_alias", 1'b0, 1'b1, 32'h1003, 32'h55);
      complete(rc);
      issue("rd_alias", 1'b1, 1'b0, 32'h0, 32'd0);
      complete(rc);
      check("alias_val", read_data, 32'h00000055);

      // Conflict: read and write together, write wins.
      issue("conflict", 1'b1, 1'b1, 32'h20, 32'h77);
      complete(rc);
      check("conflict_rdata_kept", read_data, 32'h00000055);
      issue("rd_conflict", 1'b1, 1'b0, 32'h20, 32'd0);
      complete(rc);
      check("conflict_val", read_data, 32'h00000077);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
